// File: rtl/cmsdk_ahb_pkg.sv
// Shared AHB-Lite encodings and the legal pipeline states of the command-stream master.
package cmsdk_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // Encoding is {ap_v, dp_v, err1, abort_pending}; these are the only reachable combinations.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0000,
        ST_AP         = 4'b1000,
        ST_DP         = 4'b0100,
        ST_AP_DP      = 4'b1100,
        ST_ERR1       = 4'b0110,
        ST_ERR1_ABORT = 4'b0111,
        ST_ABORT      = 4'b0001
    } pipe_state_e;

    function automatic logic [2:0] hsize_of(input logic [1:0] size);
        return (size == 2'd3) ? HSIZE_WORD : {1'b0, size};
    endfunction

endpackage

// File: rtl/cmsdk_ahb_master_lanes.sv
// Byte-lane steering for the master: address alignment, write replication and read extraction.
module cmsdk_ahb_master_lanes
    import cmsdk_ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int BE = 0
) (
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_hsize,
    input  logic [31:0]   cmd_wdata,
    output logic [AW-1:0] haddr_aligned,
    output logic [31:0]   hwdata_rep,
    input  logic [1:0]    rd_addr,
    input  logic [2:0]    rd_hsize,
    input  logic [31:0]   hrdata,
    output logic [31:0]   rd_data
);

    logic [1:0]  lane;
    logic [4:0]  shift;
    logic [31:0] mask;

    always_comb begin
        haddr_aligned = cmd_addr;
        hwdata_rep    = cmd_wdata;
        case (cmd_hsize)
            HSIZE_BYTE: hwdata_rep = {4{cmd_wdata[7:0]}};
            HSIZE_HALF: begin
                haddr_aligned[0] = 1'b0;
                hwdata_rep       = {2{cmd_wdata[15:0]}};
            end
            default:    haddr_aligned[1:0] = 2'b00;
        endcase
    end

    // Big-endian mirrors the lane index, so the lowest lane used by a halfword is 2 - offset.
    always_comb begin
        case (rd_hsize)
            HSIZE_BYTE: begin
                lane = (BE != 0) ? ~rd_addr : rd_addr;
                mask = 32'h0000_00FF;
            end
            HSIZE_HALF: begin
                lane = (BE != 0) ? {~rd_addr[1], 1'b0} : {rd_addr[1], 1'b0};
                mask = 32'h0000_FFFF;
            end
            default: begin
                lane = 2'b00;
                mask = 32'hFFFF_FFFF;
            end
        endcase
        shift   = {lane, 3'b000};
        rd_data = (hrdata >> shift) & mask;
    end

endmodule

// File: rtl/cmsdk_ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined SINGLE transfers
// with an address-phase and a data-phase register and two-cycle ERROR handling.
module cmsdk_ahb_lite_master
    import cmsdk_ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int BE = 0
) (
    input  logic          HCLK,
    input  logic          HRESET,
    // Command handshake: a command transfers on an HCLK edge with cmd_valid & cmd_ready;
    // rsp_valid is a one-cycle pulse per command, in order, with no backpressure.
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [1:0]    cmd_size,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_abort,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic          HWRITE,
    output logic [31:0]   HWDATA,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic          HMASTLOCK,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic          HRESP,
    output pipe_state_e   dbg_state
);

    logic          ap_v, ap_write;
    logic [2:0]    ap_hsize;
    logic [AW-1:0] ap_addr;
    logic [31:0]   ap_wdata;
    logic          dp_v, dp_write;
    logic [2:0]    dp_hsize;
    logic [1:0]    dp_addr;
    logic [31:0]   hwdata_q;
    logic          err1, abort_pending;

    logic [2:0]    cmd_hsize;
    logic [AW-1:0] addr_aligned;
    logic [31:0]   wdata_rep, rd_data;
    logic          accept, err_start;

    assign cmd_hsize = hsize_of(cmd_size);
    assign cmd_ready = !HRESET && !err1 && (!ap_v || HREADY);
    assign accept    = cmd_valid && cmd_ready;
    assign err_start = dp_v && HRESP && !HREADY && !err1;

    cmsdk_ahb_master_lanes #(.AW(AW), .BE(BE)) u_lanes (
        .cmd_addr      (cmd_addr),
        .cmd_hsize     (cmd_hsize),
        .cmd_wdata     (cmd_wdata),
        .haddr_aligned (addr_aligned),
        .hwdata_rep    (wdata_rep),
        .rd_addr       (dp_addr),
        .rd_hsize      (dp_hsize),
        .hrdata        (HRDATA),
        .rd_data       (rd_data)
    );

    assign HADDR     = ap_addr;
    assign HTRANS    = ap_v ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSIZE     = ap_hsize;
    assign HWRITE    = ap_write;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;
    assign dbg_state = pipe_state_e'({ap_v, dp_v, err1, abort_pending});

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_v          <= 1'b0;
            ap_write      <= 1'b0;
            ap_hsize      <= 3'b000;
            ap_addr       <= '0;
            ap_wdata      <= '0;
            dp_v          <= 1'b0;
            dp_write      <= 1'b0;
            dp_hsize      <= 3'b000;
            dp_addr       <= 2'b00;
            hwdata_q      <= '0;
            err1          <= 1'b0;
            abort_pending <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            rsp_abort     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_abort <= 1'b0;

            // The cancelled address phase reports one cycle after the errored data phase.
            if (abort_pending && !err1) begin
                rsp_valid     <= 1'b1;
                rsp_err       <= 1'b1;
                rsp_abort     <= 1'b1;
                abort_pending <= 1'b0;
            end

            if (err_start) begin
                err1          <= 1'b1;
                abort_pending <= ap_v || accept;
                ap_v          <= 1'b0;
            end else begin
                if (HREADY) begin
                    err1 <= 1'b0;
                    if (dp_v) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= HRESP;
                        rsp_rdata <= (dp_write || HRESP) ? 32'h0 : rd_data;
                    end
                    dp_v <= ap_v;
                    if (ap_v) begin
                        dp_write <= ap_write;
                        dp_hsize <= ap_hsize;
                        dp_addr  <= ap_addr[1:0];
                        hwdata_q <= ap_wdata;
                    end
                end
                if (accept) begin
                    ap_v     <= 1'b1;
                    ap_addr  <= addr_aligned;
                    ap_hsize <= cmd_hsize;
                    ap_write <= cmd_write;
                    ap_wdata <= wdata_rep;
                end else if (HREADY) begin
                    ap_v <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_lite_master.sv
// Bench for cmsdk_ahb_lite_master: directed vector table, hand-written pipeline/error/reset
// sequences, and a randomized run against a byte-addressed reference memory.
module tb_cmsdk_ahb_lite_master;
    import cmsdk_ahb_pkg::*;

    logic        HCLK, HRESET;
    logic        cmd_valid, cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [31:0] HRDATA;
    logic        HREADY, HRESP;

    logic        cmd_ready, rsp_valid, rsp_err, rsp_abort, HWRITE, HMASTLOCK;
    logic [31:0] rsp_rdata, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    pipe_state_e dbg_state;

    logic        be_cmd_ready, be_rsp_valid, be_rsp_err, be_rsp_abort, be_hwrite, be_hmastlock;
    logic [31:0] be_rsp_rdata, be_haddr, be_hwdata;
    logic [1:0]  be_htrans;
    logic [2:0]  be_hsize, be_hburst;
    logic [3:0]  be_hprot;
    pipe_state_e be_dbg_state;

    cmsdk_ahb_lite_master #(.AW(32), .BE(0)) u_dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_abort(rsp_abort),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .dbg_state(dbg_state)
    );

    cmsdk_ahb_lite_master #(.AW(32), .BE(1)) u_dut_be (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(be_cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(be_rsp_valid), .rsp_rdata(be_rsp_rdata), .rsp_err(be_rsp_err),
        .rsp_abort(be_rsp_abort),
        .HADDR(be_haddr), .HTRANS(be_htrans), .HSIZE(be_hsize), .HWRITE(be_hwrite),
        .HWDATA(be_hwdata), .HBURST(be_hburst), .HPROT(be_hprot), .HMASTLOCK(be_hmastlock),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .dbg_state(be_dbg_state)
    );

    // Clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time_limit_expired");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    // Directed vectors
    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        logic [31:0] exp_haddr;
        logic [2:0]  exp_hsize;
        logic [31:0] exp_hwdata;
        logic [31:0] exp_le;
        logic [31:0] exp_be;
    } vec_t;

    vec_t vecs[10];

    // Scoreboard / reference model
    logic [31:0] exp_q[$];
    logic [7:0]  ref_mem[64];
    logic [31:0] slv_mem[16];
    logic        s_dp_v, s_dp_write;
    logic [5:0]  s_dp_addr;
    logic [2:0]  s_dp_size;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    task automatic model_accept(input logic wr, input logic [1:0] sz, input logic [31:0] a_in,
                                input logic [31:0] d);
        int n;
        int a;
        logic [31:0] v;
        n = nbytes(sz);
        a = int'(a_in[5:0]) & ~(n - 1);
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (wr) ref_mem[a + i] = d[8*i +: 8];
            else    v[8*i +: 8] = ref_mem[a + i];
        end
        exp_q.push_back(v);
    endtask

    task automatic slave_write(input logic [5:0] a, input logic [2:0] hs, input logic [31:0] d);
        int n;
        int lane;
        n = 1 << hs;
        lane = int'(a[1:0]);
        for (int i = 0; i < n; i++)
            slv_mem[a[5:2]][8*(lane + i) +: 8] = d[8*(lane + i) +: 8];
    endtask

    initial begin
        logic [31:0] exp_v;
        int pulses;

        vecs[0] = '{1'b1, 2'd2, 32'h2000_0004, 32'hDEAD_BEEF, 32'h0,
                    32'h2000_0004, 3'd2, 32'hDEAD_BEEF, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 2'd0, 32'h0000_0003, 32'h0, 32'hA1B2_C3D4,
                    32'h0000_0003, 3'd0, 32'h0, 32'h0000_00A1, 32'h0000_00D4};
        vecs[2] = '{1'b0, 2'd1, 32'h0000_0002, 32'h0, 32'hA1B2_C3D4,
                    32'h0000_0002, 3'd1, 32'h0, 32'h0000_A1B2, 32'h0000_C3D4};
        vecs[3] = '{1'b0, 2'd1, 32'h0000_0005, 32'h0, 32'hA1B2_C3D4,
                    32'h0000_0004, 3'd1, 32'h0, 32'h0000_C3D4, 32'h0000_A1B2};
        vecs[4] = '{1'b0, 2'd2, 32'h0000_0007, 32'h0, 32'hA1B2_C3D4,
                    32'h0000_0004, 3'd2, 32'h0, 32'hA1B2_C3D4, 32'hA1B2_C3D4};
        vecs[5] = '{1'b0, 2'd3, 32'h0000_000B, 32'h0, 32'h1234_5678,
                    32'h0000_0008, 3'd2, 32'h0, 32'h1234_5678, 32'h1234_5678};
        vecs[6] = '{1'b1, 2'd0, 32'h0000_0011, 32'h1234_56AB, 32'h0,
                    32'h0000_0011, 3'd0, 32'hABAB_ABAB, 32'h0, 32'h0};
        vecs[7] = '{1'b1, 2'd1, 32'h0000_0023, 32'hFFFF_BEEF, 32'h0,
                    32'h0000_0022, 3'd1, 32'hBEEF_BEEF, 32'h0, 32'h0};
        vecs[8] = '{1'b0, 2'd0, 32'h0000_0001, 32'h0, 32'h1122_3344,
                    32'h0000_0001, 3'd0, 32'h0, 32'h0000_0033, 32'h0000_0022};
        vecs[9] = '{1'b1, 2'd2, 32'h0000_003E, 32'h0F0F_0F0F, 32'hFFFF_FFFF,
                    32'h0000_003C, 3'd2, 32'h0F0F_0F0F, 32'h0, 32'h0};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0;
        HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        HRESET = 1'b1;

        // Reset state
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_hsize_hwrite", {28'h0, HSIZE, HWRITE}, 32'h0);
        check("rst_rsp", {rsp_rdata[28:0], rsp_valid, rsp_err, rsp_abort}, 32'h0);
        check("rst_consts", {24'h0, HMASTLOCK, HBURST, HPROT}, 32'h0000_0003);
        check("rst_dbg", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_be_bus", be_haddr | be_hwdata | 32'(be_htrans) | 32'(be_hsize)
              | 32'(be_hwrite), 32'h0);
        check("rst_be_rsp", be_rsp_rdata | 32'({be_rsp_valid, be_rsp_err, be_rsp_abort,
              be_cmd_ready}) | 32'(be_dbg_state), 32'h0);
        check("rst_be_consts", {24'h0, be_hmastlock, be_hburst, be_hprot}, 32'h0000_0003);
        HRESET = 1'b0;
        #1;
        check("rel_cmd_ready", 32'(cmd_ready), 32'h1);

        // Table-driven single transfers at HREADY = 1
        for (int k = 0; k < 10; k++) begin
            drive_cmd(vecs[k].write, vecs[k].size, vecs[k].addr, vecs[k].wdata);
            HREADY = 1'b1;
            HRDATA = vecs[k].hrdata;
            tick();
            cmd_valid = 1'b0;
            check($sformatf("vec%0d_htrans", k), 32'(HTRANS), 32'(HTRANS_NONSEQ));
            check($sformatf("vec%0d_haddr", k), HADDR, vecs[k].exp_haddr);
            check($sformatf("vec%0d_hsize", k), 32'(HSIZE), 32'(vecs[k].exp_hsize));
            check($sformatf("vec%0d_hwrite", k), 32'(HWRITE), 32'(vecs[k].write));
            tick();
            if (vecs[k].write) check($sformatf("vec%0d_hwdata", k), HWDATA, vecs[k].exp_hwdata);
            tick();
            check($sformatf("vec%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
            check($sformatf("vec%0d_rsp_err", k), 32'({rsp_err, rsp_abort}), 32'h0);
            check($sformatf("vec%0d_rdata_le", k), rsp_rdata, vecs[k].exp_le);
            check($sformatf("vec%0d_rdata_be", k), be_rsp_rdata, vecs[k].exp_be);
            check($sformatf("vec%0d_idle", k), 32'(HTRANS), 32'(HTRANS_IDLE));
        end

        // Back-to-back word reads
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (c >= 1) begin
                check($sformatf("b2b%0d_htrans", c), 32'(HTRANS),
                      (c <= 4) ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_IDLE));
                if (c <= 4) check($sformatf("b2b%0d_haddr", c), HADDR, 32'(4 * (c - 1)));
                check($sformatf("b2b%0d_rsp_valid", c), 32'(rsp_valid),
                      (c >= 3 && c <= 6) ? 32'h1 : 32'h0);
                if (rsp_valid) pulses++;
                if (c >= 3 && c <= 6)
                    check($sformatf("b2b%0d_rdata", c), rsp_rdata, 32'hA000_0000 | 32'(c - 3));
            end
            if (c < 4) drive_cmd(1'b0, 2'd2, 32'(4 * c), 32'h0);
            else cmd_valid = 1'b0;
            HRDATA = (c >= 2) ? (32'hA000_0000 | 32'(c - 2)) : 32'h0;
            tick();
        end
        check("b2b_pulses", 32'(pulses), 32'd4);

        // Write with three wait states and a queued command
        drive_cmd(1'b1, 2'd2, 32'h0000_0040, 32'h55AA_55AA);
        HREADY = 1'b1;
        HRDATA = 32'h0BAD_F00D;
        tick();
        check("ws_htrans_ap", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        drive_cmd(1'b0, 2'd2, 32'h0000_0044, 32'h0);
        #1;
        check("ws_ready_free", 32'(cmd_ready), 32'h1);
        tick();
        for (int w = 0; w < 3; w++) begin
            HREADY = 1'b0;
            drive_cmd(1'b0, 2'd2, 32'h0000_0048, 32'h0);
            #1;
            check($sformatf("ws%0d_cmd_ready", w), 32'(cmd_ready), 32'h0);
            check($sformatf("ws%0d_haddr", w), HADDR, 32'h0000_0044);
            check($sformatf("ws%0d_htrans", w), 32'(HTRANS), 32'(HTRANS_NONSEQ));
            check($sformatf("ws%0d_hwdata", w), HWDATA, 32'h55AA_55AA);
            check($sformatf("ws%0d_rsp_valid", w), 32'(rsp_valid), 32'h0);
            tick();
        end
        HREADY = 1'b1;
        #1;
        check("ws_ready_release", 32'(cmd_ready), 32'h1);
        check("ws_haddr_release", HADDR, 32'h0000_0044);
        tick();
        cmd_valid = 1'b0;
        check("ws_rsp1", {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'h2);
        check("ws_haddr3", HADDR, 32'h0000_0048);
        tick();
        check("ws_rsp2_valid", 32'(rsp_valid), 32'h1);
        check("ws_rsp2_rdata", rsp_rdata, 32'h0BAD_F00D);
        tick();
        check("ws_rsp3_valid", 32'(rsp_valid), 32'h1);
        check("ws_rsp3_rdata", rsp_rdata, 32'h0BAD_F00D);
        tick();
        check("ws_quiet", 32'({rsp_valid, HTRANS}), 32'h0);

        // ERROR on the first of two pipelined reads
        drive_cmd(1'b0, 2'd2, 32'h0000_0100, 32'h0);
        tick();
        drive_cmd(1'b0, 2'd2, 32'h0000_0104, 32'h0);
        tick();
        check("err_ap2_haddr", HADDR, 32'h0000_0104);
        HRESP = 1'b1;
        HREADY = 1'b0;
        drive_cmd(1'b0, 2'd2, 32'h0000_0108, 32'h0);
        #1;
        check("err_c1_cmd_ready", 32'(cmd_ready), 32'h0);
        tick();
        check("err_c2_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check("err_c2_dbg", 32'(dbg_state), 32'(ST_ERR1_ABORT));
        check("err_c2_rsp_valid", 32'(rsp_valid), 32'h0);
        HREADY = 1'b1;
        #1;
        check("err_c2_cmd_ready", 32'(cmd_ready), 32'h0);
        tick();
        HRESP = 1'b0;
        cmd_valid = 1'b0;
        check("err_rsp1", 32'({rsp_valid, rsp_err, rsp_abort}), 32'b110);
        tick();
        check("err_rsp2", 32'({rsp_valid, rsp_err, rsp_abort}), 32'b111);
        check("err_rsp2_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
        tick();
        check("err_quiet", 32'(rsp_valid), 32'h0);

        // Reset while the data phase is waiting
        drive_cmd(1'b1, 2'd2, 32'h0000_0200, 32'hCAFE_F00D);
        HREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rst_mid_hwdata", HWDATA, 32'hCAFE_F00D);
        HREADY = 1'b0;
        tick();
        HRESET = 1'b1;
        drive_cmd(1'b0, 2'd2, 32'h0000_0300, 32'h0);
        #1;
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'h0);
        tick();
        HRESET = 1'b0;
        cmd_valid = 1'b0;
        HREADY = 1'b1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_bus", HADDR | HWDATA | 32'(HTRANS) | 32'(HSIZE) | 32'(HWRITE), 32'h0);
        check("rst_mid_dbg", 32'(dbg_state), 32'(ST_IDLE));
        #1;
        check("rst_mid_ready_after", 32'(cmd_ready), 32'h1);
        tick();
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'h0);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = slv_mem[i][8*b +: 8];
        end
        s_dp_v = 1'b0; s_dp_write = 1'b0; s_dp_addr = 6'h0; s_dp_size = 3'h0;
        for (int c = 0; c < 1500; c++) begin
            HREADY = ($urandom_range(0, 3) != 0);
            HRESP = 1'b0;
            HRDATA = s_dp_v ? slv_mem[s_dp_addr[5:2]] : $urandom;
            if (c < 1400) cmd_valid = ($urandom_range(0, 2) != 0);
            else cmd_valid = 1'b0;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_size  = 2'($urandom_range(0, 3));
            cmd_addr  = 32'h2000_0000 | 32'($urandom_range(0, 63));
            cmd_wdata = $urandom;
            #1;
            if (cmd_valid && cmd_ready) model_accept(cmd_write, cmd_size, cmd_addr, cmd_wdata);
            if (HREADY) begin
                if (s_dp_v && s_dp_write) slave_write(s_dp_addr, s_dp_size, HWDATA);
                s_dp_v = (HTRANS == HTRANS_NONSEQ);
                s_dp_addr = HADDR[5:0];
                s_dp_size = HSIZE;
                s_dp_write = HWRITE;
            end
            tick();
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rand_rdata", rsp_rdata, exp_v);
                    check("rand_flags", 32'({rsp_err, rsp_abort}), 32'h0);
                end
            end
        end
        check("rand_drain", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
